// File: rtl/led_scan_ctrl_pkg.sv
// Purpose : shared constants and the scan state encoding for the LED scan controller.
// Latency : n/a (declarations only).
// Backpr. : n/a.
package led_scan_ctrl_pkg;

    localparam int NIB_W = 4;

    localparam logic [7:0] SEG_BLANK = 8'h00;
    localparam logic [7:0] SEG_DASH  = 8'h02;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } scan_state_t;

endpackage

// File: rtl/led_scan_ctrl_bintoled.sv
// Purpose : 4-bit nibble to 7-segment pattern (a..g,dp; bit7 = a; 1 = lit).
// Latency : combinational.
// Backpr. : none.
// Ports   : i_bin - nibble in; o_seg - segment pattern, 10..15 shown as a dash, dp always 0.
module bintoled
    import led_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] i_bin,
    output logic [7:0]       o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_bin)
            4'd0: o_seg = 8'b1111_1100;
            4'd1: o_seg = 8'b0110_0000;
            4'd2: o_seg = 8'b1101_1010;
            4'd3: o_seg = 8'b1111_0010;
            4'd4: o_seg = 8'b0110_0110;
            4'd5: o_seg = 8'b1011_0110;
            4'd6: o_seg = 8'b1011_1110;
            4'd7: o_seg = 8'b1110_0000;
            4'd8: o_seg = 8'b1111_1110;
            4'd9: o_seg = 8'b1111_0110;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/led_scan_ctrl.sv
// Purpose : time-multiplexes one bintoled decoder over DIGITS common-cathode digits,
//           with a double-buffered value swapped only at frame boundaries.
// Latency : seg/dig_sel are registered, one cycle behind state/idx; a load shows from digit 0 of the next frame.
// Backpr. : none; load is always accepted, a later load before the boundary overwrites the earlier one.
// Ports   : i_clk, i_rst (sync, active-high), i_load strobe + i_value (nibble k = digit k),
//           i_lzb leading-zero blanking; o_seg, o_dig_sel one-hot, o_upd_ack pulse, o_pend.
module led_scan_ctrl
    import led_scan_ctrl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIV       = 1000,
    parameter int BLANK_CYC = 2
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_load,
    input  logic [NIB_W*DIGITS-1:0]   i_value,
    input  logic                      i_lzb,
    output logic [7:0]                o_seg,
    output logic [DIGITS-1:0]         o_dig_sel,
    output logic                      o_upd_ack,
    output logic                      o_pend
);

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [NIB_W*DIGITS-1:0]   r_active;
    logic [NIB_W*DIGITS-1:0]   r_pending;
    logic                      r_pend;
    logic                      r_upd_ack;
    logic [7:0]                r_seg;
    logic [DIGITS-1:0]         r_dig_sel;

    logic                      w_tick;
    logic                      w_boundary;
    logic [NIB_W-1:0]          w_nib;
    logic [7:0]                w_dec;
    logic [DIGITS-1:0]         w_lz_mask;
    logic [7:0]                w_seg_nxt;
    logic [DIGITS-1:0]         w_dig_nxt;

    // Bit k set when digit k is a leading zero: it and every nibble above it are 0.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [DIGITS-1:0] lz_mask(input logic [NIB_W*DIGITS-1:0] v);
        logic [DIGITS-1:0] m;
        logic              seen_nz;
        m       = '0;
        seen_nz = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (v[k*NIB_W +: NIB_W] != '0) begin
                seen_nz = 1'b1;
            end
            m[k] = !seen_nz;
        end
        return m;
    endfunction

    assign w_tick     = (r_cnt == CNT_LAST);
    assign w_boundary = w_tick && (r_idx == IDX_LAST);

    // Prescaler and digit index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // FSM: state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_BLANK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. Blank for the first BLANK_CYC counts of a slot, show for the rest.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BLANK: if (r_cnt == BLK_LAST) w_state_nxt = S_SHOW;
            S_SHOW:  if (w_tick)            w_state_nxt = S_BLANK;
            default: w_state_nxt = S_BLANK;
        endcase
    end

    // Single shared decoder, fed by the active nibble of the current slot.
    assign w_nib     = r_active[{r_idx, 2'b00} +: NIB_W];
    assign w_lz_mask = lz_mask(r_active);

    bintoled u_dec (
        .i_bin (w_nib),
        .o_seg (w_dec)
    );

    // FSM: outputs. A suppressed leading zero keeps its digit enable so slot timing is unchanged.
    always_comb begin
        w_seg_nxt = SEG_BLANK;
        w_dig_nxt = '0;
        if (r_state == S_SHOW) begin
            w_dig_nxt[r_idx] = 1'b1;
            w_seg_nxt        = (i_lzb && w_lz_mask[r_idx]) ? SEG_BLANK : w_dec;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_seg     <= SEG_BLANK;
            r_dig_sel <= '0;
        end else begin
            r_seg     <= w_seg_nxt;
            r_dig_sel <= w_dig_nxt;
        end
    end

    // Double buffer. A load on the boundary cycle bypasses pending straight into active.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active  <= '0;
            r_pending <= '0;
            r_pend    <= 1'b0;
            r_upd_ack <= 1'b0;
        end else begin
            r_upd_ack <= 1'b0;
            if (w_boundary) begin
                if (i_load) begin
                    r_active  <= i_value;
                    r_pend    <= 1'b0;
                    r_upd_ack <= 1'b1;
                end else if (r_pend) begin
                    r_active  <= r_pending;
                    r_pend    <= 1'b0;
                    r_upd_ack <= 1'b1;
                end
            end else if (i_load) begin
                r_pending <= i_value;
                r_pend    <= 1'b1;
            end
        end
    end

    assign o_seg     = r_seg;
    assign o_dig_sel = r_dig_sel;
    assign o_upd_ack = r_upd_ack;
    assign o_pend    = r_pend;

endmodule

// File: tb/tb_led_scan_ctrl.sv
// Purpose : directed bench for led_scan_ctrl with DIGITS=4, DIV=8, BLANK_CYC=2.
// Latency : t counts clock edges since reset release; digit d of frame f is lit for t = 32f+8d+3 .. 32f+8d+8.
// Backpr. : n/a.
module tb_led_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        lzb;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;
    logic        upd_ack;
    logic        pend;

    int n_cmp   = 0;
    int n_err   = 0;
    int t       = 0;
    int ack_cnt = 0;

    always #5 clk = ~clk;

    led_scan_ctrl #(
        .DIGITS    (4),
        .DIV       (8),
        .BLANK_CYC (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_load    (load),
        .i_value   (value),
        .i_lzb     (lzb),
        .o_seg     (seg),
        .o_dig_sel (dig_sel),
        .o_upd_ack (upd_ack),
        .o_pend    (pend)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        t++;
        if (upd_ack) ack_cnt++;
    endtask

    task automatic go(input int target);
        while (t < target) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg",  32'(seg), 32'h00);
            chk("rst_dig",  32'(dig_sel), 32'h0);
            chk("rst_pend", 32'(pend), 32'h0);
            chk("rst_ack",  32'(upd_ack), 32'h0);
        end
        rst     = 1'b0;
        t       = 0;
        ack_cnt = 0;
    endtask

    task automatic chk_digit(input string tag, input int at, input logic [3:0] exp_dig,
                             input logic [7:0] exp_seg);
        go(at);
        chk({tag, "_dig"}, 32'(dig_sel), 32'(exp_dig));
        chk({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0000;
        lzb   = 1'b0;

        // 1. Reset and first lit cycle
        do_reset();
        go(2);
        chk("pre_lit_dig", 32'(dig_sel), 32'h0);
        chk_digit("first_lit", 3, 4'b0001, 8'b1111_1100);

        // 2. Scan timing over a full frame: 6 lit, 2 dark per digit
        for (int tt = 4; tt <= 35; tt++) begin
            logic [3:0] e_dig;
            go(tt);
            e_dig = 4'b0000;
            if (((tt - 1) % 8) >= 2) e_dig = 4'b0001 << (((tt - 1) / 8) % 4);
            chk("scan_dig", 32'(dig_sel), 32'(e_dig));
            if (e_dig != 4'b0000) chk("scan_seg", 32'(seg), 32'h0000_00FC);
        end
        chk("scan_no_ack", 32'(ack_cnt), 32'd0);

        // 3. Load mid-frame, swap at boundary t=64
        go(40);
        load = 1'b1; value = 16'h1234;
        go(41);
        load = 1'b0;
        chk("t3_pend_set", 32'(pend), 32'h1);
        chk_digit("t3_old_d3", 60, 4'b1000, 8'b1111_1100);
        go(63);
        chk("t3_pend_hold", 32'(pend), 32'h1);
        chk("t3_no_ack_yet", 32'(upd_ack), 32'h0);
        chk_digit("t3_last_old", 64, 4'b1000, 8'b1111_1100);
        chk("t3_ack", 32'(upd_ack), 32'h1);
        chk("t3_pend_clr", 32'(pend), 32'h0);
        go(65);
        chk("t3_ack_pulse", 32'(upd_ack), 32'h0);
        chk_digit("t3_d0", 67, 4'b0001, 8'b0110_0110);
        chk_digit("t3_d1", 75, 4'b0010, 8'b1111_0010);
        chk_digit("t3_d2", 83, 4'b0100, 8'b1101_1010);
        chk_digit("t3_d3", 91, 4'b1000, 8'b0110_0000);

        // 4. Latest wins, then bypass load on the boundary cycle (edge t=160)
        go(100);
        ack_cnt = 0;
        load = 1'b1; value = 16'h0011;
        go(101);
        load = 1'b0;
        go(110);
        load = 1'b1; value = 16'h0022;
        go(111);
        load = 1'b0;
        go(128);
        chk("t4_ack", 32'(upd_ack), 32'h1);
        chk_digit("t4_d0", 131, 4'b0001, 8'b1101_1010);
        chk_digit("t4_d1", 139, 4'b0010, 8'b1101_1010);
        chk_digit("t4_d2", 147, 4'b0100, 8'b1111_1100);
        go(159);
        chk("t4_single_ack", 32'(ack_cnt), 32'd1);
        load = 1'b1; value = 16'h0099;
        go(160);
        load = 1'b0;
        chk("t4_byp_ack", 32'(upd_ack), 32'h1);
        chk("t4_byp_pend", 32'(pend), 32'h0);
        chk_digit("t4_byp_d0", 163, 4'b0001, 8'b1111_0110);
        chk_digit("t4_byp_d1", 171, 4'b0010, 8'b1111_0110);

        // 5. Leading-zero suppression
        go(175);
        load = 1'b1; value = 16'h0050;
        go(176);
        load = 1'b0;
        go(190);
        lzb = 1'b1;
        chk_digit("t5a_d0", 195, 4'b0001, 8'b1111_1100);
        chk_digit("t5a_d1", 203, 4'b0010, 8'b1011_0110);
        chk_digit("t5a_d2", 211, 4'b0100, 8'b0000_0000);
        chk_digit("t5a_d3", 219, 4'b1000, 8'b0000_0000);
        go(230);
        load = 1'b1; value = 16'h0000;
        go(231);
        load = 1'b0;
        chk_digit("t5b_d0", 259, 4'b0001, 8'b1111_1100);
        chk_digit("t5b_d1", 267, 4'b0010, 8'b0000_0000);
        chk_digit("t5b_d2", 275, 4'b0100, 8'b0000_0000);
        chk_digit("t5b_d3", 283, 4'b1000, 8'b0000_0000);
        go(290);
        load = 1'b1; value = 16'h0A00;
        go(291);
        load = 1'b0;
        chk_digit("t5c_d0", 323, 4'b0001, 8'b1111_1100);
        chk_digit("t5c_d1", 331, 4'b0010, 8'b1111_1100);
        chk_digit("t5c_d2", 339, 4'b0100, 8'b0000_0010);
        chk_digit("t5c_d3", 347, 4'b1000, 8'b0000_0000);
        // lzb is live: dropping it mid-slot relights the zero on the next output
        go(348);
        lzb = 1'b0;
        chk_digit("t5c_lzb_live", 349, 4'b1000, 8'b1111_1100);

        // 6. Reset before the boundary abandons the pending value
        go(359);
        load = 1'b1; value = 16'h5678;
        go(360);
        load = 1'b0;
        chk("t6_pend", 32'(pend), 32'h1);
        go(369);
        do_reset();
        chk_digit("t6_d0", 3, 4'b0001, 8'b1111_1100);
        chk("t6_pend_clr", 32'(pend), 32'h0);
        chk_digit("t6_d1", 11, 4'b0010, 8'b1111_1100);
        chk_digit("t6_d3", 27, 4'b1000, 8'b1111_1100);
        go(40);
        chk("t6_no_ack", 32'(ack_cnt), 32'd0);
        chk("t6_pend_end", 32'(pend), 32'h0);
        chk_digit("t6_f1_d0", 35, 4'b0001, 8'b1111_1100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
